pad_ctrl_gen: RTL and testbench
===============================

# pad_ctrl_gen

Parametrised pad-control block between SoC peripherals and the `NUM_PADS` physical I/O pads. It holds a per-pad configuration register file on APB, drives pull-enable/config, and muxes between peripheral-driven and software-overridden output/OE. It also returns each pad input through a synchroniser and an optional per-pad debounce filter. It is the configurable successor to the fixed pad frame: pad count, config width and filtering are parameters, and configuration is owned locally instead of arriving as a flat input bus.

## Interface

- `NUM_PADS`, 48, number of pads; legal 1..64.
- `CFG_W`, 6, per-pad config bits exported to the pad cells; legal 1..8.
- `DEB_W`, 8, debounce counter / limit width; legal 1..16.
- `SYNC_STAGES`, 2, input synchroniser depth; legal 2..4.

- `clk_i`  in  1  block clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `apb_psel_i`, `apb_penable_i`, `apb_pwrite_i`  in  1 each  APB control.
- `apb_paddr_i`  in  12  byte address; bits [1:0] ignored.
- `apb_pwdata_i`  in  32  write data.
- `apb_prdata_o`  out  32  read data.
- `apb_pready_o`  out  1  tied 1 (zero wait states).
- `apb_pslverr_o`  out  1  error on unmapped access.
- `core_oe_i`, `core_out_i`  in  NUM_PADS  peripheral output enable / output value.
- `core_in_o`  out  NUM_PADS  synchronised (and optionally filtered) pad input.
- `pad_in_i`  in  NUM_PADS  raw pad receiver output (asynchronous).
- `pad_oe_o`, `pad_out_o`  out  NUM_PADS  to pad cell OE / I.
- `pad_pen_o`  out  NUM_PADS  pull enable, active-high.
- `pad_cfg_o`  out  NUM_PADS x CFG_W  raw config to pad cells.

## Operation

- Register map, 32-bit words:
  - PADCFG[n] at `0x000 + 4n`, for n < NUM_PADS.
    - [CFG_W-1:0] `cfg`.
    - [8] `ovr_en`.
    - [9] `ovr_oe`.
    - [10] `ovr_out`.
    - [16] `deb_en`.
    - Other bits read 0.
  - DEB_LIMIT at `0x100`: [DEB_W-1:0].
  - IN_VAL[w] at `0x104 + 4w`, w < ceil(NUM_PADS/32): read-only, bit i = `core_in_o[32w+i]`. Bits at or above NUM_PADS read 0.
- Unmapped address:
  - `apb_pslverr_o`=1 in the access phase.
  - Read data 0; write ignored.
  - Write to IN_VAL is also an error.
- Write commits on `psel & penable & pwrite`. Read data is combinational from the address.
- Output mux, combinational:
  - `ovr_en`=1: `pad_oe_o`=`ovr_oe`, `pad_out_o`=`ovr_out`.
  - `ovr_en`=0: `core_oe_i` / `core_out_i`.
- `pad_pen_o[n]` = ~`cfg[0]`, so the pull is enabled when the bit is clear. `pad_cfg_o[n]` = `cfg`.
- Input path: `pad_in_i` passes through a SYNC_STAGES flop chain producing `s[n]`; a filter register `f[n]` and counter `c[n]` (DEB_W) follow.
  - `deb_en`=0: `f`<=`s`, `c`<=0 every cycle.
  - `deb_en`=1, `s`==`f`: `c`<=0.
  - `deb_en`=1, `s`!=`f`, `c` >= DEB_LIMIT: `f`<=`s`, `c`<=0.
  - `deb_en`=1, `s`!=`f`, otherwise: `c`<=`c`+1, saturating at all-ones.
  - `core_in_o`=`f`.

## Timing

- Reset values:
  - All PADCFG = 0: pull enabled, no override, debounce off.
  - DEB_LIMIT = 15.
  - Sync flops, `f`, `c` = 0, so `core_in_o`=0.
  - `apb_prdata_o` = 0 when `psel`=0.
  - `apb_pslverr_o` = 0.
- Write latency: PADCFG/DEB_LIMIT change is visible on outputs and in the filter the cycle after the access phase.
- Input latency:
  - Debounce off: `pad_in_i` edge reaches `core_in_o` after SYNC_STAGES+1 cycles.
  - Debounce on: SYNC_STAGES+1+L cycles, L = DEB_LIMIT.
  - A glitch shorter than L+1 sampled cycles at the sync output never reaches `core_in_o`.
- DEB_LIMIT = 0: filtered path matches the debounce-off latency.
- Lowering DEB_LIMIT below a running `c`: the pad updates on the next mismatch cycle (`>=` compare).
- Toggling `deb_en` 1->0 mid-count discards the count. 0->1 starts from `f`==`s`, with no glitch.
- Read of IN_VAL in the same cycle `f` changes returns the pre-update value.
- Reset asserted mid-operation clears all state immediately, including a pending APB write; the write is lost.

## Test plan

- Reset, then read PADCFG[0], DEB_LIMIT, IN_VAL[0] -> 0x0, 0xF, 0x0; `pad_pen_o` all 1; `pad_oe_o`==`core_oe_i`.
- Write PADCFG[5]=0x701 -> next cycle `pad_oe_o[5]`=1, `pad_out_o[5]`=1, `pad_pen_o[5]`=0, `pad_cfg_o[5]`=0x01, other pads unaffected; readback 0x701.
- Debounce off, step `pad_in_i[3]` 0->1 -> `core_in_o[3]`=1 exactly 3 cycles later (SYNC_STAGES=2).
- PADCFG[3] `deb_en`=1, DEB_LIMIT=4:
  - 3-cycle pulse -> `core_in_o[3]` stays 0.
  - Held high -> rises 7 cycles after the edge.
- Access 0x0FC with NUM_PADS=48, and write IN_VAL[0] -> `pslverr`=1, `prdata`=0, no register changes.
- Assert `rst_ni` during the access phase of a PADCFG write with `deb_en` counting -> all outputs at reset values; after release, PADCFG reads 0.

Source files
------------

// File: rtl/pad_ctrl_gen.sv
// Pad control: APB-owned per-pad config, output override mux, and a
// synchronised, optionally debounced input return path.
module pad_ctrl_gen #(
  parameter int unsigned NUM_PADS    = 48,
  parameter int unsigned CFG_W       = 6,
  parameter int unsigned DEB_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  input  logic                      apb_pwrite_i,
  input  logic [11:0]               apb_paddr_i,
  input  logic [31:0]               apb_pwdata_i,
  output logic [31:0]               apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o,
  input  logic [NUM_PADS-1:0]       core_oe_i,
  input  logic [NUM_PADS-1:0]       core_out_i,
  output logic [NUM_PADS-1:0]       core_in_o,
  input  logic [NUM_PADS-1:0]       pad_in_i,
  output logic [NUM_PADS-1:0]       pad_oe_o,
  output logic [NUM_PADS-1:0]       pad_out_o,
  output logic [NUM_PADS-1:0]       pad_pen_o,
  output logic [NUM_PADS*CFG_W-1:0] pad_cfg_o
);

  localparam int unsigned NUM_WORDS = (NUM_PADS + 31) / 32;
  localparam int unsigned IN_W      = NUM_WORDS * 32;
  localparam int unsigned DEB_WORD  = 64;
  localparam int unsigned IN_BASE   = 65;
  localparam logic [DEB_W-1:0] DEB_RESET = DEB_W'(15);
  localparam logic [DEB_W-1:0] CNT_MAX   = {DEB_W{1'b1}};

  logic [CFG_W-1:0]    cfg_q [NUM_PADS];
  logic [NUM_PADS-1:0] ovr_en_q;
  logic [NUM_PADS-1:0] ovr_oe_q;
  logic [NUM_PADS-1:0] ovr_out_q;
  logic [NUM_PADS-1:0] deb_en_q;
  logic [DEB_W-1:0]    deb_limit_q;
  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] sync_s;
  logic [NUM_PADS-1:0] filt_q;
  logic [DEB_W-1:0]    cnt_q [NUM_PADS];
  logic [IN_W-1:0]     in_ext;

  logic [31:0] word;
  logic        hit_pad;
  logic        hit_deb;
  logic        hit_in;
  logic        acc_err;
  logic        wr_en;
  logic        unused_bits;

  // Address decode: word index from the byte address
  assign word    = 32'(apb_paddr_i[11:2]);
  assign hit_pad = word < NUM_PADS;
  assign hit_deb = word == DEB_WORD;
  assign hit_in  = (word >= IN_BASE) && (word < IN_BASE + NUM_WORDS);
  assign acc_err = !(hit_pad || hit_deb || hit_in) || (apb_pwrite_i && hit_in);
  assign wr_en   = apb_psel_i && apb_penable_i && apb_pwrite_i;

  assign apb_pready_o  = 1'b1;
  assign apb_pslverr_o = apb_psel_i && apb_penable_i && acc_err;
  assign unused_bits   = ^{apb_paddr_i[1:0], apb_pwdata_i};

  assign in_ext    = IN_W'(filt_q);
  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign core_in_o = filt_q;

  // Combinational read mux; errored accesses return zero
  always_comb begin
    apb_prdata_o = '0;
    if (apb_psel_i && !acc_err) begin
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
        if (word == n) begin
          apb_prdata_o[CFG_W-1:0] = cfg_q[n];
          apb_prdata_o[8]         = ovr_en_q[n];
          apb_prdata_o[9]         = ovr_oe_q[n];
          apb_prdata_o[10]        = ovr_out_q[n];
          apb_prdata_o[16]        = deb_en_q[n];
        end
      end
      if (hit_deb) begin
        apb_prdata_o[DEB_W-1:0] = deb_limit_q;
      end
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        if (word == IN_BASE + w) begin
          apb_prdata_o = in_ext[32*w +: 32];
        end
      end
    end
  end

  // Configuration register file, committed in the APB access phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
        cfg_q[n] <= '0;
      end
      ovr_en_q    <= '0;
      ovr_oe_q    <= '0;
      ovr_out_q   <= '0;
      deb_en_q    <= '0;
      deb_limit_q <= DEB_RESET;
    end else if (wr_en) begin
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
        if (word == n) begin
          cfg_q[n]     <= apb_pwdata_i[CFG_W-1:0];
          ovr_en_q[n]  <= apb_pwdata_i[8];
          ovr_oe_q[n]  <= apb_pwdata_i[9];
          ovr_out_q[n] <= apb_pwdata_i[10];
          deb_en_q[n]  <= apb_pwdata_i[16];
        end
      end
      if (hit_deb) begin
        deb_limit_q <= apb_pwdata_i[DEB_W-1:0];
      end
    end
  end

  // Input synchroniser chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= pad_in_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Debounce filter: accept a new level once it has persisted past the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '0;
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
        if (!deb_en_q[n]) begin
          filt_q[n] <= sync_s[n];
          cnt_q[n]  <= '0;
        end else if (sync_s[n] == filt_q[n]) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] >= deb_limit_q) begin
          filt_q[n] <= sync_s[n];
          cnt_q[n]  <= '0;
        end else if (cnt_q[n] != CNT_MAX) begin
          cnt_q[n] <= cnt_q[n] + DEB_W'(1);
        end
      end
    end
  end

  // Output mux and pad-cell config fan-out
  always_comb begin
    pad_oe_o  = '0;
    pad_out_o = '0;
    pad_pen_o = '0;
    pad_cfg_o = '0;
    for (int unsigned n = 0; n < NUM_PADS; n++) begin
      pad_oe_o[n]  = ovr_en_q[n] ? ovr_oe_q[n]  : core_oe_i[n];
      pad_out_o[n] = ovr_en_q[n] ? ovr_out_q[n] : core_out_i[n];
      pad_pen_o[n] = ~cfg_q[n][0];
      pad_cfg_o[n*CFG_W +: CFG_W] = cfg_q[n];
    end
  end

endmodule

// File: tb/tb_pad_ctrl_gen.sv
// Bench for pad_ctrl_gen: register-map/filter model checked every cycle,
// plus directed literal checks on reset, override, latency and errors.
module tb_pad_ctrl_gen;

  localparam int unsigned NP = 48;
  localparam int unsigned CW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned NW = (NP + 31) / 32;
  localparam logic [31:0] PAD_MASK = 32'h0001_0700 | 32'((1 << CW) - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic pready, pslverr;
  logic [NP-1:0] core_oe, core_out, core_in, pad_in, pad_oe, pad_out, pad_pen;
  logic [NP*CW-1:0] pad_cfg;

  int errors = 0;
  int checks = 0;

  pad_ctrl_gen #(.NUM_PADS(NP), .CFG_W(CW), .DEB_W(DW), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .apb_psel_i(psel), .apb_penable_i(penable), .apb_pwrite_i(pwrite),
    .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_prdata_o(prdata),
    .apb_pready_o(pready), .apb_pslverr_o(pslverr),
    .core_oe_i(core_oe), .core_out_i(core_out), .core_in_o(core_in),
    .pad_in_i(pad_in), .pad_oe_o(pad_oe), .pad_out_o(pad_out),
    .pad_pen_o(pad_pen), .pad_cfg_o(pad_cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state: register words, delayed pad samples, filtered level, mismatch run
  logic [31:0]   m_pad [NP];
  int unsigned   m_lim;
  logic [NP-1:0] m_dly [SS];
  logic [NP-1:0] m_f;
  int unsigned   m_run [NP];

  // Model update at each clock edge (async reset)
  always @(posedge clk or negedge rst_n) begin
    logic s;
    if (!rst_n) begin
      for (int n = 0; n < NP; n++) begin
        m_pad[n] = '0;
        m_run[n] = 0;
      end
      for (int k = 0; k < SS; k++) m_dly[k] = '0;
      m_lim = 15;
      m_f   = '0;
    end else begin
      for (int n = 0; n < NP; n++) begin
        s = m_dly[SS-1][n];
        if (!m_pad[n][16]) begin
          m_f[n] = s;
          m_run[n] = 0;
        end else if (s == m_f[n]) begin
          m_run[n] = 0;
        end else if (m_run[n] >= m_lim) begin
          m_f[n] = s;
          m_run[n] = 0;
        end else if (m_run[n] < (1 << DW) - 1) begin
          m_run[n] = m_run[n] + 1;
        end
      end
      for (int k = SS - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
      m_dly[0] = pad_in;
      if (psel && penable && pwrite) begin
        if (int'(paddr[11:2]) < NP) m_pad[paddr[11:2]] = pwdata & PAD_MASK;
        else if (paddr[11:2] == 10'h040) m_lim = int'(pwdata[DW-1:0]);
      end
    end
  end

  function automatic logic map_ok();
    int unsigned w = int'(paddr[11:2]);
    if (w < NP || w == 64) return 1'b1;
    if (w >= 65 && w < 65 + NW) return !pwrite;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata();
    int unsigned w = int'(paddr[11:2]);
    logic [63:0] inv = 64'(m_f);
    if (!psel || !map_ok()) return '0;
    if (w < NP) return m_pad[w];
    if (w == 64) return 32'(m_lim);
    return inv[32*(w-65) +: 32];
  endfunction

  // Compare process: every output against the model on each falling edge
  always @(negedge clk) begin
    logic [NP-1:0] e_oe, e_out, e_pen;
    logic [NP*CW-1:0] e_cfg;
    for (int n = 0; n < NP; n++) begin
      e_oe[n]  = m_pad[n][8] ? m_pad[n][9]  : core_oe[n];
      e_out[n] = m_pad[n][8] ? m_pad[n][10] : core_out[n];
      e_pen[n] = ~m_pad[n][0];
      e_cfg[n*CW +: CW] = m_pad[n][CW-1:0];
    end
    check("m_pad_oe", 512'(pad_oe), 512'(e_oe));
    check("m_pad_out", 512'(pad_out), 512'(e_out));
    check("m_pad_pen", 512'(pad_pen), 512'(e_pen));
    check("m_pad_cfg", 512'(pad_cfg), 512'(e_cfg));
    check("m_core_in", 512'(core_in), 512'(m_f));
    check("m_prdata", 512'(prdata), 512'(exp_rdata()));
    check("m_pslverr", 512'(pslverr), 512'(psel && penable && !map_ok()));
    check("m_pready", 512'(pready), 512'(1'b1));
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [63:0] r;

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    core_oe  = 48'h0F0F_1234_5658;
    core_out = 48'hA5A5_0000_FFDF;
    pad_in   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    apb_read(12'h000, rd, er); check("rst_padcfg0", 512'(rd), 512'(0)); check("rst_err", 512'(er), 512'(0));
    apb_read(12'h100, rd, er); check("rst_deblim", 512'(rd), 512'(32'hF));
    apb_read(12'h104, rd, er); check("rst_inval0", 512'(rd), 512'(0));
    @(negedge clk);
    check("rst_pen", 512'(pad_pen), 512'({NP{1'b1}}));
    check("rst_oe", 512'(pad_oe), 512'(48'h0F0F_1234_5658));

    // Override on pad 5
    apb_write(12'h014, 32'h0000_0701, er);
    @(negedge clk);
    check("ovr_oe5", 512'(pad_oe[5]), 512'(1));
    check("ovr_out5", 512'(pad_out[5]), 512'(1));
    check("ovr_pen5", 512'(pad_pen[5]), 512'(0));
    check("ovr_cfg5", 512'(pad_cfg[5*CW +: CW]), 512'(6'h01));
    check("ovr_others", 512'(pad_oe & ~(48'(1) << 5)), 512'(48'h0F0F_1234_5658));
    apb_read(12'h014, rd, er); check("ovr_readback", 512'(rd), 512'(32'h701));

    // Debounce off: 3-cycle input latency
    @(posedge clk); #1 pad_in[3] = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("lat_off_2", 512'(core_in[3]), 512'(0));
    @(posedge clk); @(negedge clk);
    check("lat_off_3", 512'(core_in[3]), 512'(1));
    #1 pad_in[3] = 1'b0;
    repeat (5) @(posedge clk);

    // Debounce on, limit 4
    apb_write(12'h100, 32'd4, er);
    apb_write(12'h00C, 32'h0001_0000, er);
    repeat (3) @(posedge clk);
    #1 pad_in[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 pad_in[3] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("glitch_blocked", 512'(core_in[3]), 512'(0));
    end
    @(posedge clk); #1 pad_in[3] = 1'b1;
    repeat (6) @(posedge clk); @(negedge clk);
    check("lat_on_6", 512'(core_in[3]), 512'(0));
    @(posedge clk); @(negedge clk);
    check("lat_on_7", 512'(core_in[3]), 512'(1));

    // IN_VAL words
    @(posedge clk); #1 pad_in[40] = 1'b1;
    repeat (5) @(posedge clk);
    apb_read(12'h104, rd, er); check("inval0", 512'(rd), 512'(32'h8));
    apb_read(12'h108, rd, er); check("inval1", 512'(rd), 512'(32'h100));

    // Unmapped and read-only accesses
    apb_read(12'h0FC, rd, er); check("unm_rd_data", 512'(rd), 512'(0)); check("unm_rd_err", 512'(er), 512'(1));
    apb_write(12'h0FC, 32'hFFFF_FFFF, er); check("unm_wr_err", 512'(er), 512'(1));
    apb_write(12'h104, 32'hFFFF_FFFF, er); check("inval_wr_err", 512'(er), 512'(1));
    apb_read(12'h10C, rd, er); check("past_inval_err", 512'(er), 512'(1));
    apb_read(12'h0BC, rd, er); check("last_pad_err", 512'(er), 512'(0)); check("last_pad_data", 512'(rd), 512'(0));
    apb_read(12'h0C0, rd, er); check("first_gap_err", 512'(er), 512'(1));
    apb_read(12'h014, rd, er); check("keep_pad5", 512'(rd), 512'(32'h701));
    apb_read(12'h100, rd, er); check("keep_deblim", 512'(rd), 512'(32'h4));

    // DEB_LIMIT = 0 matches the unfiltered latency
    apb_write(12'h100, 32'd0, er);
    @(posedge clk); #1 pad_in[3] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("lim0_2", 512'(core_in[3]), 512'(1));
    @(posedge clk); @(negedge clk);
    check("lim0_3", 512'(core_in[3]), 512'(0));

    // Random activity with debounce on pads 0..7, limit changes mid-count
    for (int i = 0; i < 8; i++) apb_write(12'(4 * i), 32'h0001_0000 | 32'(i), er);
    repeat (60) begin
      @(posedge clk); #1;
      r = {$urandom, $urandom} & {$urandom, $urandom};
      pad_in = pad_in ^ r[NP-1:0];
    end
    apb_write(12'h100, 32'd3, er);
    repeat (100) begin
      @(posedge clk); #1;
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      pad_in = pad_in ^ r[NP-1:0];
      if ($urandom_range(0, 19) == 0) pad_in[2] = ~pad_in[2];
    end
    apb_write(12'h100, 32'd10, er);
    @(posedge clk); #1 pad_in[3] = ~pad_in[3];
    repeat (4) @(posedge clk);
    apb_write(12'h100, 32'd1, er);
    @(posedge clk); #1 pad_in[4] = ~pad_in[4];
    repeat (5) @(posedge clk);
    apb_write(12'h010, 32'h0000_0000, er);
    repeat (4) @(posedge clk);

    // Reset in the access phase of a PADCFG write while pad 3 is counting
    #1 pad_in[3] = ~pad_in[3];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h01C; pwdata = 32'h0000_0705;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pen", 512'(pad_pen), 512'({NP{1'b1}}));
    check("mid_rst_core_in", 512'(core_in), 512'(0));
    check("mid_rst_oe", 512'(pad_oe), 512'(48'h0F0F_1234_5658));
    check("mid_rst_cfg", 512'(pad_cfg), 512'(0));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    apb_read(12'h01C, rd, er); check("post_rst_pad7", 512'(rd), 512'(0));
    apb_read(12'h014, rd, er); check("post_rst_pad5", 512'(rd), 512'(0));
    apb_read(12'h100, rd, er); check("post_rst_deblim", 512'(rd), 512'(32'hF));
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
